// File: rtl/tumble_pkg.sv
// Shared types and width helpers for the tumble_board marble machine.
package tumble_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLIGHT  = 2'd1,
        ST_STOPPED = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE      = 3'd0,
        CAUSE_EMPTY     = 3'd1,
        CAUSE_INTERCEPT = 3'd2,
        CAUSE_TRAY_FULL = 3'd3,
        CAUSE_TIMEOUT   = 3'd4
    } cause_e;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned index_width(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : $clog2(n);
    endfunction

    // Bits needed to hold the values 0..n inclusive, never less than one.
    function automatic int unsigned count_width(input int unsigned n);
        return (n == 32'd0) ? 32'd1 : $clog2(n + 32'd1);
    endfunction

endpackage

// File: rtl/tumble_tray.sv
// Landed-ball FIFO: synchronous push/pop with a registered head word and clear.
module tumble_tray
    import tumble_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 1,
    localparam int unsigned NW   = count_width(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic [NW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW = index_width(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [NW-1:0] cnt_q;
    logic [DW-1:0] head_q;

    logic          empty_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic [AW-1:0] rd_nxt_s;
    logic [DW-1:0] head_d;

    // Accept/reject decisions and the head word that follows this cycle.
    always_comb begin
        empty_s  = (cnt_q == '0);
        full_s   = (cnt_q == NW'(DEPTH));
        pop_s    = pop_i & ~empty_s;
        push_s   = push_i & (~full_s | pop_s);
        rd_nxt_s = pop_s ? (rd_q + AW'(1)) : rd_q;
        // The pushed word becomes head only when nothing older survives the pop.
        if (push_s && ((cnt_q == '0) || ((cnt_q == NW'(1)) && pop_s))) begin
            head_d = din_i;
        end else begin
            head_d = mem_q[rd_nxt_s];
        end
    end

    // Storage, pointers, occupancy and head register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else if (clr_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            if (push_s) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + AW'(1);
            end
            rd_q   <= rd_nxt_s;
            head_q <= head_d;
            case ({push_s, pop_s})
                2'b10:   cnt_q <= cnt_q + NW'(1);
                2'b01:   cnt_q <= cnt_q - NW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign dout_o  = head_q;
    assign count_o = cnt_q;
    assign full_o  = full_s;
    assign empty_o = empty_s;

endmodule

// File: rtl/tumble_board.sv
// Clocked marble board: reservoirs, release FSM, tray FIFO and run termination.
// Define TUMBLE_TIMEOUT_EN to build the per-ball watchdog (cause TIMEOUT).
module tumble_board
    import tumble_pkg::*;
#(
    parameter int unsigned COLOURS    = 2,
    parameter int unsigned BALLS      = 8,
    parameter int unsigned TRAY_DEPTH = 16,
    parameter int unsigned TIMEOUT    = 15,
    localparam int unsigned CW        = index_width(COLOURS),
    localparam int unsigned TW        = count_width(TRAY_DEPTH)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               reload_i,
    input  logic [COLOURS-1:0] sink_i,
    input  logic               intercept_i,
    output logic [COLOURS-1:0] ball_out_o,
    output logic [CW-1:0]      colour_o,
    output logic               in_flight_o,
    output logic               stopped_o,
    output logic [2:0]         stop_cause_o,
    output logic [COLOURS-1:0] empty_o,
    input  logic               tray_pop_i,
    output logic               tray_valid_o,
    output logic [CW-1:0]      tray_data_o,
    output logic [TW-1:0]      tray_count_o
);

    localparam int unsigned RW = count_width(BALLS);

    state_e             state_q;
    cause_e             cause_q;
    logic [COLOURS-1:0] ball_out_q;
    logic [CW-1:0]      colour_q;
    logic [RW-1:0]      res_q [COLOURS];
`ifdef TUMBLE_TIMEOUT_EN
    localparam int unsigned WW = count_width(TIMEOUT);
    logic [WW-1:0]      wd_q;
`endif

    logic [CW-1:0]      sink_idx_s;
    logic [COLOURS-1:0] empty_s;
    logic               push_s;
    logic               pop_ok_s;
    logic               clr_s;
    logic               tray_full_s;
    logic               tray_empty_s;

    // Lowest set sink bit wins; scanning downward leaves the smallest index.
    always_comb begin
        sink_idx_s = '0;
        for (int i = int'(COLOURS) - 1; i >= 0; i--) begin
            sink_idx_s = sink_i[i] ? CW'(i) : sink_idx_s;
        end
    end

    // Reservoir empty flags and tray handshake derived from current state.
    always_comb begin
        empty_s = '0;
        for (int c = 0; c < int'(COLOURS); c++) begin
            empty_s[c] = (res_q[c] == '0);
        end
        push_s   = (state_q == ST_FLIGHT) & ~intercept_i & (|sink_i);
        pop_ok_s = tray_pop_i & ~tray_empty_s;
        clr_s    = reload_i & (state_q != ST_FLIGHT);
    end

    // Run FSM with reservoir counters, watchdog and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cause_q    <= CAUSE_NONE;
            ball_out_q <= '0;
            colour_q   <= '0;
            for (int c = 0; c < int'(COLOURS); c++) begin
                res_q[c] <= RW'(BALLS);
            end
`ifdef TUMBLE_TIMEOUT_EN
            wd_q       <= '0;
`endif
        end else begin
            ball_out_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (reload_i) begin
                        cause_q <= CAUSE_NONE;
                        for (int c = 0; c < int'(COLOURS); c++) begin
                            res_q[c] <= RW'(BALLS);
                        end
                    end else if (start_i) begin
                        if (res_q[0] != '0) begin
                            ball_out_q[0] <= 1'b1;
                            res_q[0]      <= res_q[0] - RW'(1);
                            colour_q      <= '0;
                            state_q       <= ST_FLIGHT;
`ifdef TUMBLE_TIMEOUT_EN
                            wd_q          <= '0;
`endif
                        end else begin
                            state_q <= ST_STOPPED;
                            cause_q <= CAUSE_EMPTY;
                        end
                    end
                end
                ST_FLIGHT: begin
                    if (intercept_i) begin
                        state_q <= ST_STOPPED;
                        cause_q <= CAUSE_INTERCEPT;
                    end else if (|sink_i) begin
                        // A full tray with no pop loses the landed ball.
                        if (tray_full_s && !pop_ok_s) begin
                            state_q <= ST_STOPPED;
                            cause_q <= CAUSE_TRAY_FULL;
                        end else if (res_q[sink_idx_s] != '0) begin
                            ball_out_q[sink_idx_s] <= 1'b1;
                            res_q[sink_idx_s]      <= res_q[sink_idx_s] - RW'(1);
                            colour_q               <= sink_idx_s;
`ifdef TUMBLE_TIMEOUT_EN
                            wd_q                   <= '0;
`endif
                        end else begin
                            state_q <= ST_STOPPED;
                            cause_q <= CAUSE_EMPTY;
                        end
                    end
`ifdef TUMBLE_TIMEOUT_EN
                    else if (wd_q == WW'(TIMEOUT)) begin
                        state_q <= ST_STOPPED;
                        cause_q <= CAUSE_TIMEOUT;
                    end else begin
                        wd_q <= wd_q + WW'(1);
                    end
`endif
                end
                ST_STOPPED: begin
                    if (reload_i) begin
                        state_q <= ST_IDLE;
                        cause_q <= CAUSE_NONE;
                        for (int c = 0; c < int'(COLOURS); c++) begin
                            res_q[c] <= RW'(BALLS);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cause_q <= CAUSE_NONE;
                end
            endcase
        end
    end

    tumble_tray #(
        .DEPTH (TRAY_DEPTH),
        .DW    (CW)
    ) u_tray (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (clr_s),
        .push_i  (push_s),
        .pop_i   (tray_pop_i),
        .din_i   (colour_q),
        .dout_o  (tray_data_o),
        .count_o (tray_count_o),
        .full_o  (tray_full_s),
        .empty_o (tray_empty_s)
    );

    assign ball_out_o   = ball_out_q;
    assign colour_o     = colour_q;
    assign in_flight_o  = (state_q == ST_FLIGHT);
    assign stopped_o    = (state_q == ST_STOPPED);
    assign stop_cause_o = cause_q;
    assign empty_o      = empty_s;
    assign tray_valid_o = ~tray_empty_s;

endmodule
